// File: rtl/dec_nbload_cam_pkg.sv
// Sizing and writeback bundle for the decode-stage non-blocking-load tracker.
package dec_nbload_cam_pkg;

    localparam int unsigned RV_LSU_NUM_NBLOAD       = 4;
    localparam int unsigned RV_LSU_NUM_NBLOAD_WIDTH = $clog2(RV_LSU_NUM_NBLOAD);

    typedef struct packed {
        logic       wen;
        logic [4:0] waddr;
    } dec_nbload_wb_pkt_t;

endpackage

// File: rtl/swerv_types.sv
// Shared core types. load_cam_pkt_t is the per-entry layout of the
// non-blocking-load CAM, used by decode and by trace/debug consumers.
package swerv_types;

    localparam int unsigned LOAD_CAM_TAG_W = 2;

    typedef struct packed {
        logic                      valid;
        logic                      wb;
        logic [LOAD_CAM_TAG_W-1:0] tag;
        logic [4:0]                rd;
    } load_cam_pkt_t;

endpackage

// File: rtl/dec_nbload_entry.sv
// One tracker entry: valid/wb/rd state plus its next-state logic.
// Ports:
//   clk, rst_l     clock, synchronous active-low reset
//   alloc          this entry is being allocated this cycle
//   alloc_rd       destination register of the allocation
//   inv            this entry's load was squashed
//   data           load data returned for this entry's tag
//   data_error     returned data is in error
//   waw_clr        a newer writer targets this entry's rd
//   pkt            registered entry state (tag field is constant IDX)
//   wb_fire_c      this entry's data return produces a GPR write
module dec_nbload_entry
    import swerv_types::*;
#(
    parameter int unsigned IDX = 0
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          alloc,
    input  logic [4:0]    alloc_rd,
    input  logic          inv,
    input  logic          data,
    input  logic          data_error,
    input  logic          waw_clr,
    output load_cam_pkt_t pkt,
    output logic          wb_fire_c
);

    localparam int unsigned PKT_TAG_W = $bits(load_cam_pkt_t) - 7;

    load_cam_pkt_t q;
    load_cam_pkt_t d;

    // Free is applied before alloc so a same-cycle re-allocation lands valid.
    always_comb begin
        d     = q;
        d.tag = PKT_TAG_W'(IDX);
        if (waw_clr) begin
            d.wb = 1'b0;
        end
        if (inv || (data && q.valid)) begin
            d.valid = 1'b0;
            d.wb    = 1'b0;
        end
        if (alloc) begin
            d.valid = 1'b1;
            d.wb    = |alloc_rd;
            d.rd    = alloc_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            q.valid <= 1'b0;
            q.wb    <= 1'b0;
            q.tag   <= PKT_TAG_W'(IDX);
            q.rd    <= 5'd0;
        end else begin
            q <= d;
        end
    end

    // Squash wins over a same-cycle data return.
    assign wb_fire_c = data && q.valid && q.wb && !inv && !data_error;
    assign pkt       = q;

    // Allocating over a live entry that is not being freed is illegal use.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            assert (!(alloc && q.valid && !inv && !data));
        end
    end

endmodule

// File: rtl/dec_nbload_cam.sv
// Decode-stage tracker of outstanding non-blocking loads. Entries are indexed
// directly by tag; produces the delayed GPR writeback, per-source hazard
// stalls and a full indication for the LSU.
// Ports:
//   clk, rst_l                  clock, synchronous active-low reset
//   alloc_valid/tag/rd          new non-blocking load from the LSU
//   inv_valid/tag               squash of an outstanding load
//   data_valid/tag/error        load data return
//   i0/i1_wen_wb, _waddr_wb     in-order GPR writes (WAW against entries)
//   rs_addr, rs_en              decode sources {i1rs2, i1rs1, i0rs2, i0rs1}
//   nb_wen, nb_waddr            registered GPR writeback
//   rs_block                    per-source hazard stall
//   cam_full                    every entry valid
//   cam_pkt                     entry state for debug/trace
module dec_nbload_cam
    import swerv_types::*;
    import dec_nbload_cam_pkg::*;
#(
    parameter int unsigned NUM_NBLOAD = RV_LSU_NUM_NBLOAD,
    parameter int unsigned TAG_W      = RV_LSU_NUM_NBLOAD_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_l,
    input  logic                            alloc_valid,
    input  logic [TAG_W-1:0]                alloc_tag,
    input  logic [4:0]                      alloc_rd,
    input  logic                            inv_valid,
    input  logic [TAG_W-1:0]                inv_tag,
    input  logic                            data_valid,
    input  logic [TAG_W-1:0]                data_tag,
    input  logic                            data_error,
    input  logic                            i0_wen_wb,
    input  logic [4:0]                      i0_waddr_wb,
    input  logic                            i1_wen_wb,
    input  logic [4:0]                      i1_waddr_wb,
    input  logic [3:0][4:0]                 rs_addr,
    input  logic [3:0]                      rs_en,
    output logic                            nb_wen,
    output logic [4:0]                      nb_waddr,
    output logic [3:0]                      rs_block,
    output logic                            cam_full,
    output load_cam_pkt_t [NUM_NBLOAD-1:0]  cam_pkt
);

    logic [NUM_NBLOAD-1:0]          alloc_hit;
    logic [NUM_NBLOAD-1:0]          inv_hit;
    logic [NUM_NBLOAD-1:0]          data_hit;
    logic [NUM_NBLOAD-1:0]          waw_clr;
    logic [NUM_NBLOAD-1:0]          fire;
    logic [NUM_NBLOAD-1:0]          valid_vec;
    load_cam_pkt_t [NUM_NBLOAD-1:0] pkt;

    dec_nbload_wb_pkt_t wb_d;
    dec_nbload_wb_pkt_t wb_q;
    logic [3:0]         rs_hit;

    // Per-entry tag decode and WAW detection against newer writers.
    for (genvar i = 0; i < NUM_NBLOAD; i++) begin : g_entry
        assign alloc_hit[i] = alloc_valid && (alloc_tag == TAG_W'(i));
        assign inv_hit[i]   = inv_valid   && (inv_tag   == TAG_W'(i));
        assign data_hit[i]  = data_valid  && (data_tag  == TAG_W'(i));
        assign valid_vec[i] = pkt[i].valid;

        // The entry being allocated this cycle is not its own newer writer.
        assign waw_clr[i] = !alloc_hit[i] && pkt[i].valid &&
                            ((alloc_valid && (alloc_rd    == pkt[i].rd)) ||
                             (i0_wen_wb   && (i0_waddr_wb == pkt[i].rd)) ||
                             (i1_wen_wb   && (i1_waddr_wb == pkt[i].rd)));

        dec_nbload_entry #(
            .IDX (i)
        ) u_entry (
            .clk        (clk),
            .rst_l      (rst_l),
            .alloc      (alloc_hit[i]),
            .alloc_rd   (alloc_rd),
            .inv        (inv_hit[i]),
            .data       (data_hit[i]),
            .data_error (data_error),
            .waw_clr    (waw_clr[i]),
            .pkt        (pkt[i]),
            .wb_fire_c  (fire[i])
        );
    end

    // At most one entry fires (single data port), so an OR-mux suffices.
    always_comb begin
        wb_d = '0;
        for (int i = 0; i < NUM_NBLOAD; i++) begin
            if (fire[i]) begin
                wb_d.wen   = 1'b1;
                wb_d.waddr = wb_d.waddr | pkt[i].rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    // Hazard: pending entries plus the writeback still in flight.
    always_comb begin
        rs_hit   = '0;
        rs_block = '0;
        for (int k = 0; k < 4; k++) begin
            rs_hit[k] = wb_q.wen && (wb_q.waddr == rs_addr[k]);
            for (int i = 0; i < NUM_NBLOAD; i++) begin
                if (pkt[i].valid && pkt[i].wb && (pkt[i].rd == rs_addr[k])) begin
                    rs_hit[k] = 1'b1;
                end
            end
            rs_block[k] = rs_en[k] && (rs_addr[k] != 5'd0) && rs_hit[k];
        end
    end

    assign nb_wen   = wb_q.wen;
    assign nb_waddr = wb_q.waddr;
    assign cam_full = &valid_vec;
    assign cam_pkt  = pkt;

endmodule

// File: tb/tb_dec_nbload_cam.sv
module tb_dec_nbload_cam;
    import swerv_types::*;

    logic                 clk = 1'b0;
    logic                 rst_l;
    logic                 alloc_valid;
    logic [1:0]           alloc_tag;
    logic [4:0]           alloc_rd;
    logic                 inv_valid;
    logic [1:0]           inv_tag;
    logic                 data_valid;
    logic [1:0]           data_tag;
    logic                 data_error;
    logic                 i0_wen_wb;
    logic [4:0]           i0_waddr_wb;
    logic                 i1_wen_wb;
    logic [4:0]           i1_waddr_wb;
    logic [3:0][4:0]      rs_addr;
    logic [3:0]           rs_en;
    logic                 nb_wen;
    logic [4:0]           nb_waddr;
    logic [3:0]           rs_block;
    logic                 cam_full;
    load_cam_pkt_t [3:0]  cam_pkt;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic [4:0]  waddr;
        int unsigned at;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dec_nbload_cam dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .alloc_valid (alloc_valid),
        .alloc_tag   (alloc_tag),
        .alloc_rd    (alloc_rd),
        .inv_valid   (inv_valid),
        .inv_tag     (inv_tag),
        .data_valid  (data_valid),
        .data_tag    (data_tag),
        .data_error  (data_error),
        .i0_wen_wb   (i0_wen_wb),
        .i0_waddr_wb (i0_waddr_wb),
        .i1_wen_wb   (i1_wen_wb),
        .i1_waddr_wb (i1_waddr_wb),
        .rs_addr     (rs_addr),
        .rs_en       (rs_en),
        .nb_wen      (nb_wen),
        .nb_waddr    (nb_waddr),
        .rs_block    (rs_block),
        .cam_full    (cam_full),
        .cam_pkt     (cam_pkt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        alloc_valid = 1'b0; alloc_tag = '0; alloc_rd = '0;
        inv_valid   = 1'b0; inv_tag   = '0;
        data_valid  = 1'b0; data_tag  = '0; data_error = 1'b0;
        i0_wen_wb   = 1'b0; i0_waddr_wb = '0;
        i1_wen_wb   = 1'b0; i1_waddr_wb = '0;
    endtask

    task automatic alloc(input logic [1:0] tag, input logic [4:0] rd);
        alloc_valid = 1'b1; alloc_tag = tag; alloc_rd = rd;
    endtask

    task automatic data(input logic [1:0] tag);
        data_valid = 1'b1; data_tag = tag;
    endtask

    // Expected write appears in the cycle after the consuming edge.
    task automatic expect_wb(input logic [4:0] rd);
        exp_t e;
        e.waddr = rd;
        e.at    = cyc + 1;
        exp_q.push_back(e);
    endtask

    function automatic logic [3:0] valids();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = cam_pkt[i].valid;
        return v;
    endfunction

    // Monitor: every writeback pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL wb_missing: got no write expected waddr %0d at cycle %0d", exp_q[0].waddr, exp_q[0].at);
            void'(exp_q.pop_front());
        end
        if (nb_wen === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got write waddr %0d expected none (cycle %0d)", nb_waddr, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (nb_waddr !== e.waddr || cyc != e.at) begin
                    errors++;
                    $display("FAIL wb_match: got waddr %0d cycle %0d expected waddr %0d cycle %0d", nb_waddr, cyc, e.waddr, e.at);
                end
            end
        end
    end

    initial begin
        clr();
        rst_l   = 1'b0;
        rs_en   = '0;
        rs_addr = '0;
        step(); step();
        rst_l = 1'b1;
        chk("rst_valid", 32'(valids()), 32'h0);
        chk("rst_full", 32'(cam_full), 32'h0);
        chk("rst_wen", 32'(nb_wen), 32'h0);
        chk("rst_block", 32'(rs_block), 32'h0);

        // Reset mid-operation drops entries and the in-flight return.
        alloc(2'd0, 5'd3); step(); clr();
        alloc(2'd1, 5'd4); step(); clr();
        chk("two_valid", 32'(valids()), 32'h3);
        data(2'd0); rst_l = 1'b0; step(); rst_l = 1'b1; clr();
        chk("rst_mid_valid", 32'(valids()), 32'h0);
        chk("rst_mid_wen", 32'(nb_wen), 32'h0);
        chk("rst_mid_full", 32'(cam_full), 32'h0);

        // Basic allocate, hazard, writeback.
        rs_en = 4'b0011; rs_addr[0] = 5'd5; rs_addr[1] = 5'd6;
        alloc(2'd1, 5'd5); step(); clr();
        chk("basic_block", 32'(rs_block), 32'h1);
        step();
        data(2'd1); expect_wb(5'd5); step(); clr();
        chk("basic_free", 32'(cam_pkt[1].valid), 32'h0);
        chk("basic_inflight", 32'(rs_block), 32'h1);
        step();
        chk("basic_clear", 32'(rs_block), 32'h0);

        // WAW from pipe-0 writeback.
        alloc(2'd0, 5'd7); step(); clr();
        i0_wen_wb = 1'b1; i0_waddr_wb = 5'd7; step(); clr();
        chk("waw_i0_wb", 32'(cam_pkt[0].wb), 32'h0);
        chk("waw_i0_valid", 32'(cam_pkt[0].valid), 32'h1);
        rs_en = 4'b0001; rs_addr[0] = 5'd7; #1;
        chk("waw_noblock", 32'(rs_block), 32'h0);
        data(2'd0); step(); clr();
        chk("waw_i0_free", 32'(cam_pkt[0].valid), 32'h0);

        // WAW from pipe-1 writeback and from a newer allocation.
        alloc(2'd2, 5'd8); step(); clr();
        i1_wen_wb = 1'b1; i1_waddr_wb = 5'd8; step(); clr();
        chk("waw_i1_wb", 32'(cam_pkt[2].wb), 32'h0);
        alloc(2'd3, 5'd9); step(); clr();
        alloc(2'd1, 5'd9); step(); clr();
        chk("waw_alloc_old", 32'(cam_pkt[3].wb), 32'h0);
        chk("waw_alloc_new", 32'(cam_pkt[1].wb), 32'h1);
        data(2'd2); step(); clr();
        data(2'd3); step(); clr();
        data(2'd1); expect_wb(5'd9); step(); clr();
        chk("waw_all_free", 32'(valids()), 32'h0);

        // Same-tag collisions.
        alloc(2'd2, 5'd11); step(); clr();
        inv_valid = 1'b1; inv_tag = 2'd2; data(2'd2); step(); clr();
        chk("inv_data_free", 32'(cam_pkt[2].valid), 32'h0);
        alloc(2'd3, 5'd9); step(); clr();
        alloc(2'd3, 5'd10); data(2'd3); expect_wb(5'd9); step(); clr();
        chk("realloc_valid", 32'(cam_pkt[3].valid), 32'h1);
        chk("realloc_rd", 32'(cam_pkt[3].rd), 32'd10);
        chk("realloc_wb", 32'(cam_pkt[3].wb), 32'h1);
        data(2'd3); expect_wb(5'd10); step(); clr();

        // Full, then an errored return frees without writing.
        for (int t = 0; t < 4; t++) begin
            alloc(2'(t), 5'(12 + t)); step(); clr();
        end
        chk("full_set", 32'(cam_full), 32'h1);
        data(2'd0); data_error = 1'b1; step(); clr();
        chk("full_clear", 32'(cam_full), 32'h0);
        chk("err_free", 32'(cam_pkt[0].valid), 32'h0);
        for (int t = 1; t < 4; t++) begin
            inv_valid = 1'b1; inv_tag = 2'(t); step(); clr();
        end
        chk("inv_all_free", 32'(valids()), 32'h0);

        // Destination x0 never writes and never blocks.
        rs_en = 4'b0001; rs_addr[0] = 5'd0;
        alloc(2'd1, 5'd0); step(); clr();
        chk("x0_valid", 32'(cam_pkt[1].valid), 32'h1);
        chk("x0_wb", 32'(cam_pkt[1].wb), 32'h0);
        chk("x0_block", 32'(rs_block), 32'h0);
        data(2'd1); step(); clr();
        chk("x0_free", 32'(cam_pkt[1].valid), 32'h0);

        step(); step(); step();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec_nbload_cam.md
Name: dec_nbload_cam

Overview:
- Tracks outstanding non-blocking loads between LSU issue and register-file writeback, in the decode stage.
- Holds one entry per NBLOAD tag. Each entry uses the shared load_cam_pkt_t layout: valid, wb, tag, rd.
- Produces the delayed GPR writeback when load data returns.
- Raises register-hazard stalls for decode and a full indication for the LSU.

Parameters:
- NUM_NBLOAD, default `RV_LSU_NUM_NBLOAD (4): number of entries. Must be a power of two.
- TAG_W, default `RV_LSU_NUM_NBLOAD_WIDTH (2): tag width, equal to log2(NUM_NBLOAD).

Ports:
- clk  in  1  core clock.
- rst_l  in  1  reset; one clock, synchronous, active-low.
- alloc_valid  in  1  LSU issued a non-blocking load this cycle.
- alloc_tag  in  TAG_W  tag of the new load.
- alloc_rd  in  5  destination register of the new load.
- inv_valid  in  1  the load was squashed in the pipeline; free its entry.
- inv_tag  in  TAG_W  tag to free.
- data_valid  in  1  load data returned.
- data_tag  in  TAG_W  tag of the returned data.
- data_error  in  1  returned data is in error; suppress the write.
- i0_wen_wb  in  1  pipe-0 in-order GPR write this cycle.
- i0_waddr_wb  in  5  pipe-0 write address.
- i1_wen_wb  in  1  pipe-1 in-order GPR write this cycle.
- i1_waddr_wb  in  5  pipe-1 write address.
- rs_addr  in  4x5  decode sources {i1rs2, i1rs1, i0rs2, i0rs1}.
- rs_en  in  4  source-valid bits, same order as rs_addr.
- nb_wen  out  1  GPR writeback enable.
- nb_waddr  out  5  GPR writeback address.
- rs_block  out  4  per-source hazard; decode must stall.
- cam_full  out  1  all entries valid; LSU must not allocate.
- cam_pkt  out  NUM_NBLOAD x load_cam_pkt_t  entry state for debug/trace.

Behaviour:
- Reset, synchronous on rst_l=0:
  - All entries are cleared: valid=0, wb=0, rd=0.
  - nb_wen=0, nb_waddr=0, rs_block=0, cam_full=0.
  - An in-flight writeback is dropped.
- Indexing: entry i is addressed directly by tag i. No search is needed for allocate, invalidate or data return. The cam_pkt tag field is constant i.
- Allocate:
  - alloc_valid sets, at the next edge: valid=1, wb=1, rd=alloc_rd.
  - alloc_rd=0 allocates with wb=0, so no write ever occurs.
- WAW, one rule applied in three cases: any valid entry whose rd matches a newer writer gets wb cleared at the next edge. Its data return then frees the entry with no write. The newer writers are:
  - a newer allocation to the same rd;
  - i0_wen_wb with i0_waddr_wb equal to the entry's rd;
  - i1_wen_wb with i1_waddr_wb equal to the entry's rd.
  - The entry being allocated in the same cycle is exempt from this rule.
- Invalidate: inv_valid clears the entry's valid and wb at the next edge.
- Data return:
  - data_valid on a valid entry frees it at the next edge.
  - Registered writeback: if wb=1 and data_error=0, the following cycle nb_wen=1 and nb_waddr=rd. Latency is exactly 1 cycle.
  - data_valid on an invalid entry is ignored.
- Simultaneous events on the same tag:
  - inv and data: inv wins; no writeback.
  - alloc and data/inv: the free is applied first, then the alloc. The new entry ends valid, and the old occupant's writeback, if eligible, still fires.
  - alloc to a valid entry that is not being freed is an illegal use. Simulation assertion; the alloc overwrites.
- Hazard:
  - rs_block[k]=1 when rs_en[k]=1, rs_addr[k]!=0, and some entry has valid&wb with rd==rs_addr[k].
  - Combinational from registered state only, so it does not include same-cycle allocs.
  - Also blocks when nb_wen=1 and nb_waddr==rs_addr[k], because the writeback is still in flight.
- cam_full: combinational AND of all valid bits from state.
- nb_wen is a single-cycle pulse; at most one per cycle because there is one data return port.

Decomposition:
- load_cam_pkt_t stays in swerv_types.
- Add to the package:
  - `RV_LSU_NUM_NBLOAD;
  - a dec_nbload_wb_pkt_t {wen, waddr[4:0]} for the writeback bundle.
- One sub-module: dec_nbload_entry, a single-entry state register with next-state logic. It is instantiated NUM_NBLOAD times via generate.
- The hazard compare stays at top level.

Test Plan:
- Reset: assert rst_l=0 mid-operation with 2 entries valid -> next cycle all cam_pkt valid=0, nb_wen=0, cam_full=0.
- Basic: alloc tag1 rd=5 -> rs_block[0]=1 for i0rs1=5. Data tag1 two cycles later -> nb_wen=1, nb_waddr=5 one cycle after; entry1 valid=0; rs_block clears once nb_wen drops.
- WAW: alloc tag0 rd=7; i0_wen_wb rd=7 -> entry0 wb=0. Data tag0 -> no nb_wen; entry freed.
- Collisions: inv and data same cycle on tag2 -> no write, entry freed. Alloc tag3 while data returns tag3 (rd=9, new rd=10) -> nb_waddr=9 next cycle; entry3 valid with rd=10.
- Full: alloc tags 0..3 -> cam_full=1. data_error on tag0 -> no nb_wen, cam_full=0.
- rd=0: alloc rd=0 -> no rs_block for x0; data return gives no write.
